// File: rtl/tm1638_key_events.sv
// TM1638 key debouncer and edge-event queue. Optional auto-repeat tracker
// is built when TM1638_KEY_AUTOREPEAT_EN is defined.
module tm1638_key_events #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic [7:0] keys_raw,
    output logic [7:0] keys_stable,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [2:0] event_key,
    output logic       event_press,
    output logic       event_repeat,
    output logic       overflow,
    input  logic       clear_overflow
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]         r_sync1, r_sync2;
    logic [7:0][CW-1:0] r_cnt;
    logic [7:0]         r_pend, r_pend_type;
    logic [4:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [AW:0]        r_count;

    logic [7:0] w_raise, w_grant;
    logic [2:0] w_sel;
    logic       w_any, w_pop, w_push_ok, w_push, w_ovf;
    logic [4:0] w_din, w_head;
    logic       w_rpt_req;
    logic [2:0] w_rpt_key;

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            keys_stable <= '0;
            r_cnt       <= '0;
        end else begin
            r_sync1 <= keys_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 8; k++) begin
                if (r_sync2[k] == keys_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CMAX) begin
                    keys_stable[k] <= ~keys_stable[k];
                    r_cnt[k]       <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Lowest pending key wins; a repeat request only fills an idle push slot.
    always_comb begin
        w_raise = '0;
        w_grant = '0;
        w_sel   = '0;
        w_any   = 1'b0;
        w_push  = 1'b0;
        w_din   = '0;
        for (int k = 0; k < 8; k++)
            w_raise[k] = (r_sync2[k] != keys_stable[k]) && (r_cnt[k] == CMAX);
        for (int k = 0; k < 8; k++) begin
            if (r_pend[k] && !w_any) begin
                w_any = 1'b1;
                w_sel = 3'(k);
            end
        end
        w_pop     = event_valid && event_ready;
        w_push_ok = (r_count < (AW+1)'(FIFO_DEPTH)) || w_pop;
        if (w_any && w_push_ok) begin
            w_push         = 1'b1;
            w_grant[w_sel] = 1'b1;
            w_din          = {1'b0, r_pend_type[w_sel], w_sel};
        end else if (w_rpt_req && w_push_ok) begin
            w_push = 1'b1;
            w_din  = {1'b1, 1'b1, w_rpt_key};
        end
        w_ovf = |(w_raise & r_pend & ~w_grant);
    end

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            r_pend      <= '0;
            r_pend_type <= '0;
            overflow    <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_raise[k]) begin
                    r_pend[k]      <= 1'b1;
                    r_pend_type[k] <= r_sync2[k];
                end else if (w_grant[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
            if (w_ovf)               overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_1MHz) begin
        if (w_push) r_mem[r_wptr] <= w_din;
    end

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_mem[r_rptr];
    assign event_valid  = (r_count != '0);
    assign event_key    = event_valid ? w_head[2:0] : 3'd0;
    assign event_press  = event_valid & w_head[3];
    assign event_repeat = event_valid & w_head[4];

`ifdef TM1638_KEY_AUTOREPEAT_EN
    logic        r_rpt_act;
    logic [2:0]  r_rpt_key;
    logic [31:0] r_rpt_cnt;
    logic [7:0]  w_press;
    logic [2:0]  w_press_key;

    assign w_rpt_req = r_rpt_act && (r_rpt_cnt == '0) && keys_stable[r_rpt_key];
    assign w_rpt_key = r_rpt_key;

    // Several simultaneous presses: track the highest index.
    always_comb begin
        w_press     = w_raise & r_sync2;
        w_press_key = '0;
        for (int k = 0; k < 8; k++)
            if (w_press[k]) w_press_key = 3'(k);
    end

    always_ff @(posedge clk_1MHz or negedge rst) begin
        if (!rst) begin
            r_rpt_act <= 1'b0;
            r_rpt_key <= '0;
            r_rpt_cnt <= '0;
        end else if (|w_press) begin
            r_rpt_act <= 1'b1;
            r_rpt_key <= w_press_key;
            r_rpt_cnt <= 32'(REPEAT_DELAY - 1);
        end else if (r_rpt_act && w_raise[r_rpt_key]) begin
            r_rpt_act <= 1'b0;
        end else if (w_rpt_req) begin
            r_rpt_cnt <= 32'(REPEAT_PERIOD - 1);
        end else if (r_rpt_act && r_rpt_cnt != '0) begin
            r_rpt_cnt <= r_rpt_cnt - 1'b1;
        end
    end
`else
    assign w_rpt_req = 1'b0;
    assign w_rpt_key = 3'd0;
`endif
endmodule

// File: tb/tb_tm1638_key_events.sv
// Scoreboard bench for tm1638_key_events: expected events are queued when
// stimulus is driven and compared as the consumer pops them.
module tb_tm1638_key_events;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] keys_raw = '0;
    logic [7:0] keys_stable;
    logic       event_valid, event_ready = 1'b0;
    logic [2:0] event_key;
    logic       event_press, event_repeat, overflow;
    logic       clear_overflow = 1'b0;

    int n_chk = 0, n_err = 0, cyc = 0;
    bit mon_en = 1'b1;
    logic [4:0] exp_q[$];

    tm1638_key_events #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .clk_1MHz(clk), .rst(rst), .keys_raw(keys_raw), .keys_stable(keys_stable),
        .event_valid(event_valid), .event_ready(event_ready), .event_key(event_key),
        .event_press(event_press), .event_repeat(event_repeat), .overflow(overflow),
        .clear_overflow(clear_overflow));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (event_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    // Consumer side: every accepted event must match the queue head.
    always @(negedge clk) begin
        if (mon_en && rst && event_valid && event_ready) begin
            if (exp_q.size() == 0) chk("ev_unexpected", 0, 1);
            else chk("ev", int'({event_repeat, event_press, event_key}), int'(exp_q.pop_front()));
        end
`ifndef TM1638_KEY_AUTOREPEAT_EN
        if (event_repeat) chk("repeat_tied0", 1, 0);
`endif
    end

    initial begin
        bit ok;
        int c0;
        bit found;
        #23;
        chk("rst_stable", keys_stable, 0);
        chk("rst_valid", event_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_head", {event_repeat, event_press, event_key}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(2);

        // Single press on key 3 with exact latency
        keys_raw = 8'h08;
        tick(5);
        chk("t0p4_stable", keys_stable[3], 0);
        tick(1);
        chk("t0p5_stable", keys_stable[3], 1);
        chk("t0p5_valid", event_valid, 0);
        tick(1);
        chk("t0p6_valid", event_valid, 1);
        chk("t0p6_head", {event_repeat, event_press, event_key}, {2'b01, 3'd3});
        exp_q.push_back({2'b01, 3'd3});
        event_ready = 1'b1;
        tick(2);
        keys_raw = 8'h00;
        exp_q.push_back({2'b00, 3'd3});
        tick(12);
        chk("press_drain", exp_q.size(), 0);

        // 3-cycle glitch is filtered
        keys_raw = 8'h20;
        tick(3);
        keys_raw = 8'h00;
        tick(12);
        chk("glitch_stable", keys_stable, 0);
        chk("glitch_valid", event_valid, 0);

        // Simultaneous presses drain lowest index first, back to back
        keys_raw = 8'h52;
        exp_q.push_back({2'b01, 3'd1});
        exp_q.push_back({2'b01, 3'd4});
        exp_q.push_back({2'b01, 3'd6});
        wait_valid(20, ok);
        chk("sim_k1", event_key, 1);
        @(negedge clk);
        chk("sim_k4", event_key, 4);
        @(negedge clk);
        chk("sim_k6", event_key, 6);
        #2;
        keys_raw = 8'h00;
        exp_q.push_back({2'b00, 3'd1});
        exp_q.push_back({2'b00, 3'd4});
        exp_q.push_back({2'b00, 3'd6});
        tick(14);
        chk("sim_drain", exp_q.size(), 0);

        // Full FIFO, two pending, then re-trigger a pending key
        event_ready = 1'b0;
        keys_raw = 8'h3F;
        tick(10);
        chk("full_noovf", overflow, 0);
        chk("full_head", {event_repeat, event_press, event_key}, {2'b01, 3'd0});
        tick(1);
        chk("full_head_hold", event_key, 0);
        keys_raw = 8'h1F;
        tick(8);
        chk("ovf_set", overflow, 1);
        for (int k = 0; k < 5; k++) exp_q.push_back({2'b01, 3'(k)});
        exp_q.push_back({2'b00, 3'd5});
        event_ready = 1'b1;
        tick(12);
        chk("ovf_drain", exp_q.size(), 0);
        chk("ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Reset with three queued releases
        event_ready = 1'b0;
        keys_raw = 8'h18;
        tick(10);
        chk("mid_valid", event_valid, 1);
        chk("mid_head", {event_press, event_key}, {1'b0, 3'd0});
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", event_valid, 0);
        chk("mid_rst_stable", keys_stable, 0);
        chk("mid_rst_head", {event_repeat, event_press, event_key}, 0);
        keys_raw = 8'h00;
        exp_q.delete();
        tick(3);
        rst = 1'b1;
        event_ready = 1'b1;
        tick(15);
        chk("post_rst_valid", event_valid, 0);
        chk("post_rst_stable", keys_stable, 0);

`ifdef TM1638_KEY_AUTOREPEAT_EN
        // Auto-repeat: delay 20 from the press edge, then every 8
        mon_en = 1'b0;
        keys_raw = 8'h04;
        wait_valid(20, ok);
        chk("ar_press", {event_repeat, event_press, event_key}, {2'b01, 3'd2});
        c0 = cyc;
        wait_valid(40, ok);
        chk("ar_rep1", {event_repeat, event_press, event_key}, {2'b11, 3'd2});
        chk("ar_delay", cyc - c0, 19);
        c0 = cyc;
        wait_valid(20, ok);
        chk("ar_rep2", {event_repeat, event_key}, {1'b1, 3'd2});
        chk("ar_period", cyc - c0, 8);
        #2;
        keys_raw = 8'h84;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (event_valid && event_repeat && event_key == 3'd7) found = 1'b1;
        end
        chk("ar_retarget", found, 1);
        #2;
        keys_raw = 8'h00;
        tick(20);
        mon_en = 1'b1;
`else
        keys_raw = 8'h04;
        exp_q.push_back({2'b01, 3'd2});
        tick(40);
        keys_raw = 8'h00;
        exp_q.push_back({2'b00, 3'd2});
        tick(12);
        chk("norep_drain", exp_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
